// File: rtl/fir_mac_seq_if.sv
// rtl/fir_mac_seq_if.sv - sample handshake, output and coefficient-write bundle for fir_mac_seq
interface fir_mac_seq_if #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int N    = 8,
    parameter int AW   = $clog2(N),
    parameter int ACCW = DW + CW + $clog2(N)
);
    logic                   in_valid;
    logic                   in_ready;
    logic signed [DW-1:0]   xn;
    logic                   out_valid;
    logic signed [ACCW-1:0] yn;
    logic                   coef_we;
    logic [AW-1:0]          coef_addr;
    logic signed [CW-1:0]   coef_data;

    modport master (
        output in_valid, xn, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, yn
    );

    modport slave (
        input  in_valid, xn, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, yn
    );
endinterface

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - time-multiplexed N-tap FIR, one signed MAC per clock, programmable taps
module fir_mac_seq #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int N    = 8,
    parameter int AW   = $clog2(N),
    parameter int ACCW = DW + CW + $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    fir_mac_seq_if.slave bus
);
    localparam int            PW   = DW + CW;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                 state;
    state_t                 state_n;
    logic signed [DW-1:0]   d [N];
    logic signed [CW-1:0]   b [N];
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] yn_q;
    logic signed [PW-1:0]   prod;
    logic [AW-1:0]          idx;
    logic                   out_valid_q;
    logic                   in_ready_c;
    logic                   accept;
    logic                   coef_hit;

    assign accept   = in_ready_c && bus.in_valid;
    assign coef_hit = bus.coef_we && ({1'b0, bus.coef_addr} < (AW + 1)'(N));
    assign prod     = b[idx] * d[idx];
    assign sum      = acc + {{(ACCW - PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // DONE is folded into the final MAC edge; it only ever appears as a recovery path.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.in_valid) state_n = MAC;
            MAC:     if (idx == LAST) state_n = IDLE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = (state == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                d[i] <= '0;
                b[i] <= CW'(i + 1);
            end
            acc         <= '0;
            idx         <= '0;
            yn_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            // A tap written on the edge it is read still feeds the old value to the MAC.
            if (coef_hit) begin
                b[bus.coef_addr] <= bus.coef_data;
            end
            if (accept) begin
                d[0] <= bus.xn;
                for (int i = 1; i < N; i++) begin
                    d[i] <= d[i-1];
                end
                acc <= '0;
                idx <= '0;
            end else if (state == MAC) begin
                acc <= sum;
                if (idx == LAST) begin
                    idx         <= '0;
                    yn_q        <= sum;
                    out_valid_q <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.yn        = yn_q;
endmodule

// File: doc/fir_mac_seq.md
# fir_mac_seq

Parametrised, time-multiplexed FIR filter: one signed multiplier-accumulator evaluates an N-tap convolution over N clock cycles per input sample. Coefficients are run-time programmable, and data moves through a valid/ready input handshake and a valid-pulse output. It is the next generation of the team's fixed 4-tap FIR and sits in the same sample-processing datapath. After reset it reproduces the old block's taps (b[i] = i+1).

## Interface
- DW, 16, input sample width (signed)
- CW, 16, coefficient width (signed)
- N, 8, number of taps (N ≥ 2)
- AW, $clog2(N), coefficient address width
- ACCW, DW+CW+$clog2(N), accumulator and output width

Ports:
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  xn is valid
- in_ready  out  1  block can accept a sample
- xn  in  DW  signed input sample
- out_valid  out  1  one-cycle pulse, yn is new
- yn  out  ACCW  signed filter output, held between pulses
- coef_we  in  1  coefficient write strobe
- coef_addr  in  AW  tap index to write
- coef_data  in  CW  signed coefficient value

## Operation
- The FSM has three states: IDLE, MAC and DONE. The only reason DONE exists is to make the FSM explicit. It lasts zero cycles and is merged into the final MAC edge.
- IDLE: in_ready = 1. On an edge where in_valid && in_ready:
  - Shift the delay line: d[0] <= xn, and d[i] <= d[i-1] for i = 1..N-1.
  - Set acc <= 0 and idx <= 0.
  - Go to MAC.
- MAC: in_ready = 0. Each edge performs acc <= acc + b[idx]*d[idx] and idx <= idx+1.
  - On the edge where idx == N-1: yn <= acc + b[N-1]*d[N-1], out_valid <= 1, FSM goes to IDLE.
- out_valid is high for exactly one cycle and is otherwise 0. The output has no backpressure.
- Arithmetic:
  - Operands are signed, and the product is the full DW+CW bits.
  - Products are sign-extended to ACCW before they are added.
  - There is no saturation or rounding. ACCW is sized so the sum cannot overflow.
- Coefficient writes:
  - coef_we with coef_addr < N writes b[coef_addr] on that edge.
  - Writes are accepted in any state.
  - A write with coef_addr ≥ N is ignored.
- Write/read collision: if the MAC reads b[k] on the same edge that b[k] is written, the MAC uses the old value. The new value applies from the next edge.
- Samples offered while in_ready = 0 are not consumed. The source must hold xn/in_valid until it is accepted.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State = IDLE, in_ready = 1, out_valid = 0, yn = 0.
  - All d[i] = 0, acc = 0, idx = 0.
  - b[i] = i+1.
- Latency: a sample is accepted at edge E0. MAC runs on edges E1..EN. yn and out_valid update at EN, so out_valid is high in the cycle after EN.
- in_ready goes low after E0 and is high again after EN, in the same cycle that out_valid is high. A new sample can therefore be accepted at edge EN+1.
- Maximum throughput is 1 sample per N+1 cycles. With in_valid held high, accepts occur every N+1 edges.
- Reset asserted mid-MAC:
  - The computation is aborted with no out_valid.
  - The delay line is cleared.
  - The coefficients return to their defaults.
- Reset deasserted: the first accept is possible on the first rising edge after deassertion.

## Test plan
- Reset check: assert reset mid-run → immediately in_ready = 1, out_valid = 0, yn = 0. Then read back via impulse: xn = 1 followed by zeros, default coefficients, N = 8 → yn sequence 1,2,3,4,5,6,7,8,0, each with a single out_valid pulse 9 cycles after its accept.
- Sign and width: xn = -32768 as an impulse, with b[0] written to -32768 → yn = +1073741824. Also xn = -5 with b[0] = 3 → yn = -15, sign-extended to ACCW.
- Coefficient programming: write b[0..7] = {-2,0,0,0,0,0,0,1}, then feed xn = 100,0,0,0,0,0,0,0 → outputs -200,0,0,0,0,0,0,100. A write to address ≥ N (non-power-of-2 N, e.g. N = 5, addr 6) leaves all taps unchanged.
- Handshake: in_valid held high with a ramp xn = 1,2,3 → accepts exactly every N+1 cycles; in_ready = 0 throughout MAC; no sample is dropped or duplicated; out_valid and in_ready are both high in the same cycle.
- Collision: write b[3] = 50 on the exact edge the MAC reads tap 3 → that output uses the old b[3]. The next sample uses 50.
- Reset mid-operation: assert reset at E3 of a computation → no out_valid for that sample. The next impulse after reset gives the default-coefficient response starting at 1.
